// File: rtl/lap_timer_core.sv
// lap_timer_core: prescaled stopwatch/countdown with a show-ahead lap FIFO.
// Define LAP_TIMER_AUTORELOAD_EN to make the countdown reload from preset at zero.
module lap_timer_core #(
    parameter int TICK_DIV  = 100,
    parameter int WIDTH     = 12,
    parameter int LAP_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start_stop,
    input  logic                         lap,
    input  logic                         clear,
    input  logic                         load,
    input  logic [WIDTH-1:0]             preset,
    input  logic                         mode,
    input  logic                         lap_rd,
    output logic [WIDTH-1:0]             count,
    output logic                         running,
    output logic                         time_up,
    output logic                         ovf,
    output logic [WIDTH-1:0]             lap_out,
    output logic                         lap_valid,
    output logic                         lap_full,
    output logic                         lap_drop,
    output logic [$clog2(LAP_DEPTH):0]   lap_cnt
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(LAP_DEPTH);
`ifdef LAP_TIMER_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             run_q, run_d, tu_q, tu_d, ovf_q, ovf_d, drop_q, drop_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [LAP_DEPTH];
    logic             tick, full, pop, push, we;

    always_comb begin
        tick = run_q && (pre_q == PRE_MAX);
        pre_d = run_q ? (tick ? '0 : pre_q + PW'(1)) : pre_q;
        count_d = count_q;
        run_d = run_q;
        tu_d = AUTO ? 1'b0 : tu_q;
        ovf_d = ovf_q;
        if (tick && !mode) begin
            count_d = count_q + WIDTH'(1);
            ovf_d = ovf_q | (&count_q);
        end else if (tick) begin
            count_d = (count_q == '0) ? (AUTO ? preset : '0) : count_q - WIDTH'(1);
            if (count_q == WIDTH'(1) || (!AUTO && count_q == '0)) tu_d = 1'b1;
            run_d = AUTO || count_q > WIDTH'(1);
        end
        // Stopped countdown at zero cannot restart unless it will reload
        if (start_stop && run_q) begin
            run_d = 1'b0;
        end else if (start_stop && (AUTO || !mode || count_q != '0)) begin
            run_d = 1'b1;
            tu_d = 1'b0;
        end
        if (load || clear) begin
            run_d = 1'b0;
            pre_d = '0;
            tu_d = 1'b0;
            count_d = clear ? '0 : preset;
        end
        if (clear) ovf_d = 1'b0;
    end

    always_comb begin
        full = cnt_q == FULL_CNT;
        pop = lap_rd && cnt_q != '0;
        push = lap && (!full || pop);
        we = push && !clear;
        wr_d = clear ? '0 : wr_q + AW'(push);
        rd_d = clear ? '0 : rd_q + AW'(pop);
        cnt_d = clear ? '0 : (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
        drop_d = !clear && (drop_q || (lap && !push));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pre_q <= '0;
            count_q <= '0;
            run_q <= 1'b0;
            tu_q <= 1'b0;
            ovf_q <= 1'b0;
            drop_q <= 1'b0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pre_q <= pre_d;
            count_q <= count_d;
            run_q <= run_d;
            tu_q <= tu_d;
            ovf_q <= ovf_d;
            drop_q <= drop_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            if (we) mem_q[wr_q] <= count_q;
        end
    end

    assign count = count_q;
    assign running = run_q;
    assign time_up = tu_q;
    assign ovf = ovf_q;
    assign lap_valid = cnt_q != '0;
    assign lap_full = full;
    assign lap_drop = drop_q;
    assign lap_cnt = cnt_q;
    assign lap_out = lap_valid ? mem_q[rd_q] : '0;
endmodule
